free_list_ctrl: RTL and testbench

FREE_LIST_CTRL -- requirements
Module: free_list_ctrl

---
 rtl/free_list_ctrl_pkg.sv | 12 +
 rtl/free_list_ctrl.sv | 122 ++++++++++++
 tb/tb_free_list_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/free_list_ctrl_pkg.sv
// Shared rename definitions: physical register width, pool sizes and the
// physical register tag type. Used by the free list and the rename stage.
package free_list_ctrl_pkg;

  localparam int PHYS_W   = 6;
  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 32;
  localparam int COUNT_W  = PHYS_W + 1;

  typedef logic [PHYS_W-1:0] phys_reg_t;

endpackage

// File: rtl/free_list_ctrl.sv
// Physical register free list for a two-wide rename stage.
// The pool is a circular queue of free register tags: rename pops from head,
// retire pushes stale tags at tail.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   alloc_req_a/b                 rename slot A/B wants a new destination tag
//   alloc_ready                   pool covers every request this cycle
//   alloc_phy_a/b                 candidate tag for slot A/B (0 when not requested)
//   free_valid_a/b, free_phy_a/b  retire returns a stale tag on port A/B
//   free_count                    registered number of free entries
//   empty                         free_count == 0
//   overflow_err                  sticky: a free was dropped because the pool was full
module free_list_ctrl
  import free_list_ctrl_pkg::*;
#(
  parameter int NUM_PHYS = free_list_ctrl_pkg::NUM_PHYS,
  parameter int NUM_ARCH = free_list_ctrl_pkg::NUM_ARCH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alloc_req_a,
  input  logic               alloc_req_b,
  output logic               alloc_ready,
  output phys_reg_t          alloc_phy_a,
  output phys_reg_t          alloc_phy_b,
  input  logic               free_valid_a,
  input  logic               free_valid_b,
  input  phys_reg_t          free_phy_a,
  input  phys_reg_t          free_phy_b,
  output logic [COUNT_W-1:0] free_count,
  output logic               empty,
  output logic               overflow_err
);

  localparam int                 FREE_INIT  = NUM_PHYS - NUM_ARCH;
  localparam logic [COUNT_W-1:0] COUNT_MAX  = COUNT_W'(NUM_PHYS - 1);
  localparam logic [COUNT_W-1:0] COUNT_INIT = COUNT_W'(FREE_INIT);
  localparam logic [PHYS_W-1:0]  TAIL_INIT  = PHYS_W'(FREE_INIT);

  phys_reg_t          pool [NUM_PHYS];
  logic [PHYS_W-1:0]  head;
  logic [PHYS_W-1:0]  tail;
  logic [COUNT_W-1:0] count;
  logic               overflow_q;

  logic [1:0]         req_num;
  logic [1:0]         alloc_num;
  logic [1:0]         free_num;
  logic [PHYS_W-1:0]  head_b;
  logic [PHYS_W-1:0]  tail_b;
  logic [COUNT_W-1:0] base_count;
  logic               valid_a_nz;
  logic               valid_b_nz;
  logic               accept_a;
  logic               accept_b;
  logic               drop_any;

  always_comb begin
    req_num     = {1'b0, alloc_req_a} + {1'b0, alloc_req_b};
    // Uses the registered count, so a tag freed this cycle cannot be granted
    // until the next one.
    alloc_ready = (count >= {{(COUNT_W-2){1'b0}}, req_num});
    alloc_num   = alloc_ready ? req_num : 2'd0;

    head_b      = head + {{(PHYS_W-1){1'b0}}, alloc_req_a};
    alloc_phy_a = alloc_req_a ? pool[head]   : '0;
    alloc_phy_b = alloc_req_b ? pool[head_b] : '0;

    // The fullness limit is judged against the count after this cycle's
    // allocations, so an alloc+free pair at the limit loses nothing.
    base_count  = count - {{(COUNT_W-2){1'b0}}, alloc_num};

    // p0 is never a valid free tag; it is silently ignored.
    valid_a_nz  = free_valid_a && (free_phy_a != '0);
    valid_b_nz  = free_valid_b && (free_phy_b != '0);
    accept_a    = valid_a_nz && (base_count < COUNT_MAX);
    accept_b    = valid_b_nz &&
                  ((base_count + {{(COUNT_W-1){1'b0}}, accept_a}) < COUNT_MAX);
    drop_any    = (valid_a_nz && !accept_a) || (valid_b_nz && !accept_b);

    free_num    = {1'b0, accept_a} + {1'b0, accept_b};
    tail_b      = tail + {{(PHYS_W-1){1'b0}}, accept_a};
  end

  // One register per pool entry; tail and tail_b differ whenever both ports
  // write, so at most one port targets a given entry.
  for (genvar g = 0; g < NUM_PHYS; g++) begin : g_pool
    localparam phys_reg_t RST_VAL = (g < FREE_INIT) ? phys_reg_t'(NUM_ARCH + g)
                                                    : phys_reg_t'(0);
    always_ff @(posedge clk) begin
      if (reset) begin
        pool[g] <= RST_VAL;
      end else if (accept_a && (tail == PHYS_W'(g))) begin
        pool[g] <= free_phy_a;
      end else if (accept_b && (tail_b == PHYS_W'(g))) begin
        pool[g] <= free_phy_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= TAIL_INIT;
      count      <= COUNT_INIT;
      overflow_q <= 1'b0;
    end else begin
      head  <= head + {{(PHYS_W-2){1'b0}}, alloc_num};
      tail  <= tail + {{(PHYS_W-2){1'b0}}, free_num};
      count <= base_count + {{(COUNT_W-2){1'b0}}, free_num};
      if (drop_any) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign free_count   = count;
  assign empty        = (count == '0);
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_free_list_ctrl.sv
module tb_free_list_ctrl;

  logic       clk;
  logic       reset;
  logic       alloc_req_a, alloc_req_b;
  logic       alloc_ready;
  logic [5:0] alloc_phy_a, alloc_phy_b;
  logic       free_valid_a, free_valid_b;
  logic [5:0] free_phy_a, free_phy_b;
  logic [6:0] free_count;
  logic       empty;
  logic       overflow_err;

  int n_cmp = 0;
  int n_bad = 0;

  free_list_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req_a  (alloc_req_a),
    .alloc_req_b  (alloc_req_b),
    .alloc_ready  (alloc_ready),
    .alloc_phy_a  (alloc_phy_a),
    .alloc_phy_b  (alloc_phy_b),
    .free_valid_a (free_valid_a),
    .free_valid_b (free_valid_b),
    .free_phy_a   (free_phy_a),
    .free_phy_b   (free_phy_b),
    .free_count   (free_count),
    .empty        (empty),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req_a  = 1'b0;
    alloc_req_b  = 1'b0;
    free_valid_a = 1'b0;
    free_valid_b = 1'b0;
    free_phy_a   = 6'd0;
    free_phy_b   = 6'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (free_count !== 7'd32) begin n_bad++; $display("FAIL reset_count: got %0d want 32", free_count); end
    n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL reset_empty: got %b want 0", empty); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow_err); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_noreq: got %b want 1", alloc_ready); end
    n_cmp++; if (alloc_phy_a !== 6'd0) begin n_bad++; $display("FAIL reset_phy_a_noreq: got %0d want 0", alloc_phy_a); end
  endtask

  task automatic test_dual_alloc();
    do_reset();
    alloc_req_a = 1'b1; alloc_req_b = 1'b1;
    #1;
    n_cmp++; if (alloc_phy_a !== 6'd32) begin n_bad++; $display("FAIL dual_phy_a: got %0d want 32", alloc_phy_a); end
    n_cmp++; if (alloc_phy_b !== 6'd33) begin n_bad++; $display("FAIL dual_phy_b: got %0d want 33", alloc_phy_b); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL dual_ready: got %b want 1", alloc_ready); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (free_count !== 7'd30) begin n_bad++; $display("FAIL dual_count: got %0d want 30", free_count); end
    alloc_req_a = 1'b1;
    #1;
    n_cmp++; if (alloc_phy_a !== 6'd34) begin n_bad++; $display("FAIL dual_next_a: got %0d want 34", alloc_phy_a); end
    tick();
    idle_inputs();
  endtask

  task automatic test_single_b();
    do_reset();
    alloc_req_b = 1'b1;
    #1;
    n_cmp++; if (alloc_phy_a !== 6'd0) begin n_bad++; $display("FAIL single_b_phy_a: got %0d want 0", alloc_phy_a); end
    n_cmp++; if (alloc_phy_b !== 6'd32) begin n_bad++; $display("FAIL single_b_phy_b: got %0d want 32", alloc_phy_b); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (free_count !== 7'd31) begin n_bad++; $display("FAIL single_b_count: got %0d want 31", free_count); end
    alloc_req_a = 1'b1;
    #1;
    n_cmp++; if (alloc_phy_a !== 6'd33) begin n_bad++; $display("FAIL single_b_next_a: got %0d want 33", alloc_phy_a); end
    tick();
    idle_inputs();
  endtask

  // Leaves the pool empty with head = tail = 32.
  task automatic test_drain_stall();
    do_reset();
    for (int k = 0; k < 15; k++) begin
      alloc_req_a = 1'b1; alloc_req_b = 1'b1;
      #1;
      n_cmp++; if (alloc_phy_a !== 6'(32 + 2*k)) begin n_bad++; $display("FAIL drain_a[%0d]: got %0d want %0d", k, alloc_phy_a, 32 + 2*k); end
      n_cmp++; if (alloc_phy_b !== 6'(33 + 2*k)) begin n_bad++; $display("FAIL drain_b[%0d]: got %0d want %0d", k, alloc_phy_b, 33 + 2*k); end
      tick();
    end
    alloc_req_b = 1'b0;
    #1;
    n_cmp++; if (alloc_phy_a !== 6'd62) begin n_bad++; $display("FAIL drain_last_a: got %0d want 62", alloc_phy_a); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (free_count !== 7'd1) begin n_bad++; $display("FAIL drain_count1: got %0d want 1", free_count); end
    alloc_req_a = 1'b1; alloc_req_b = 1'b1;
    #1;
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready: got %b want 0", alloc_ready); end
    n_cmp++; if (alloc_phy_a !== 6'd63) begin n_bad++; $display("FAIL stall_cand_a: got %0d want 63", alloc_phy_a); end
    n_cmp++; if (alloc_phy_b !== 6'd0) begin n_bad++; $display("FAIL stall_cand_b: got %0d want 0", alloc_phy_b); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (free_count !== 7'd1) begin n_bad++; $display("FAIL stall_count: got %0d want 1", free_count); end
    alloc_req_a = 1'b1;
    #1;
    n_cmp++; if (alloc_phy_a !== 6'd63) begin n_bad++; $display("FAIL stall_head_kept: got %0d want 63", alloc_phy_a); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", alloc_ready); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (free_count !== 7'd0) begin n_bad++; $display("FAIL drained_count: got %0d want 0", free_count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL drained_empty: got %b want 1", empty); end
  endtask

  // Runs straight after test_drain_stall with an empty pool.
  task automatic test_free_while_empty();
    free_valid_a = 1'b1; free_phy_a = 6'd5;
    alloc_req_a = 1'b1; alloc_req_b = 1'b1;
    #1;
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL empty_free_ready: got %b want 0", alloc_ready); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (free_count !== 7'd1) begin n_bad++; $display("FAIL empty_free_count: got %0d want 1", free_count); end
    n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL empty_free_empty: got %b want 0", empty); end
    alloc_req_a = 1'b1;
    #1;
    n_cmp++; if (alloc_phy_a !== 6'd5) begin n_bad++; $display("FAIL empty_free_grant: got %0d want 5", alloc_phy_a); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL empty_free_ready2: got %b want 1", alloc_ready); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (free_count !== 7'd0) begin n_bad++; $display("FAIL empty_free_count0: got %0d want 0", free_count); end
  endtask

  task automatic test_free_p0();
    do_reset();
    free_valid_a = 1'b1; free_phy_a = 6'd0;
    free_valid_b = 1'b1; free_phy_b = 6'd40;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (free_count !== 7'd33) begin n_bad++; $display("FAIL p0_count: got %0d want 33", free_count); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL p0_ovf: got %b want 0", overflow_err); end
    for (int k = 0; k < 16; k++) begin
      alloc_req_a = 1'b1; alloc_req_b = 1'b1;
      tick();
    end
    idle_inputs();
    alloc_req_a = 1'b1; alloc_req_b = 1'b1;
    #1;
    n_cmp++; if (alloc_phy_a !== 6'd40) begin n_bad++; $display("FAIL p0_enqueued: got %0d want 40", alloc_phy_a); end
    n_cmp++; if (alloc_phy_b !== 6'd0) begin n_bad++; $display("FAIL p0_next_slot: got %0d want 0", alloc_phy_b); end
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL p0_ready: got %b want 0", alloc_ready); end
    idle_inputs();
  endtask

  task automatic test_wrap_overflow();
    do_reset();
    // Alloc one and free one per cycle; tag freed in cycle k is granted in cycle k+32.
    for (int k = 0; k < 80; k++) begin
      alloc_req_a  = 1'b1;
      free_valid_a = 1'b1;
      free_phy_a   = 6'(1 + (k % 63));
      #1;
      n_cmp++;
      if (alloc_phy_a !== ((k < 32) ? 6'(32 + k) : 6'(k - 31))) begin
        n_bad++;
        $display("FAIL wrap_grant[%0d]: got %0d want %0d", k, alloc_phy_a, (k < 32) ? 32 + k : k - 31);
      end
      tick();
    end
    idle_inputs();
    #1;
    n_cmp++; if (free_count !== 7'd32) begin n_bad++; $display("FAIL wrap_count: got %0d want 32", free_count); end
    for (int k = 0; k < 15; k++) begin
      free_valid_a = 1'b1; free_phy_a = 6'd7;
      free_valid_b = 1'b1; free_phy_b = 6'd8;
      tick();
    end
    idle_inputs();
    #1;
    n_cmp++; if (free_count !== 7'd62) begin n_bad++; $display("FAIL fill_count: got %0d want 62", free_count); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL fill_ovf_early: got %b want 0", overflow_err); end
    free_valid_a = 1'b1; free_phy_a = 6'd7;
    free_valid_b = 1'b1; free_phy_b = 6'd8;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (free_count !== 7'd63) begin n_bad++; $display("FAIL ovf_count: got %0d want 63", free_count); end
    n_cmp++; if (overflow_err !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow_err); end
    tick();
    n_cmp++; if (overflow_err !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky_idle: got %b want 1", overflow_err); end
    alloc_req_a = 1'b1;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (free_count !== 7'd62) begin n_bad++; $display("FAIL ovf_alloc_count: got %0d want 62", free_count); end
    n_cmp++; if (overflow_err !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky_alloc: got %b want 1", overflow_err); end
    do_reset();
    #1;
    n_cmp++; if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL ovf_cleared: got %b want 0", overflow_err); end
    n_cmp++; if (free_count !== 7'd32) begin n_bad++; $display("FAIL ovf_reset_count: got %0d want 32", free_count); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_dual_alloc();
    test_single_b();
    test_drain_stall();
    test_free_while_empty();
    test_free_p0();
    test_wrap_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
